// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus header with master count, owner encodings and grant decode.
package bus_arbiter_pkg;
   localparam int BUS_MASTER_CH = 4;
   localparam int BUS_OWNER_W = 2;
   typedef logic [BUS_OWNER_W-1:0] owner_t;
   typedef logic [BUS_MASTER_CH-1:0] mvec_t;
   typedef enum logic [BUS_OWNER_W-1:0] {
      BUS_OWNER_MASTER_0 = 2'd0,
      BUS_OWNER_MASTER_1 = 2'd1,
      BUS_OWNER_MASTER_2 = 2'd2,
      BUS_OWNER_MASTER_3 = 2'd3
   } bus_owner_e;
   function automatic mvec_t owner_onehot(owner_t o);
      return mvec_t'(1) << o;
   endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: active-low request/grant lines, owner index and timeout pulse.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;
   logic m0_req_, m1_req_, m2_req_, m3_req_;
   logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
   owner_t owner;
   logic timeout_err;
   modport master (
      output m0_req_, m1_req_, m2_req_, m3_req_,
      input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, timeout_err
   );
   modport slave (
      input  m0_req_, m1_req_, m2_req_, m3_req_,
      output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, timeout_err
   );
endinterface

// File: rtl/bus_arb_rr_pick.sv
// bus_arb_rr_pick: round-robin search for the next requester starting at owner+1.
module bus_arb_rr_pick
   import bus_arbiter_pkg::*;
(
   input  owner_t owner,
   input  mvec_t  req,
   input  logic   excl,
   output owner_t next_owner,
   output logic   found
);
   // descending scan so the nearest requester after owner wins; offset 4 is owner itself
   always_comb begin
      next_owner = owner;
      found = 1'b0;
      for (int i = BUS_MASTER_CH; i >= 1; i--)
         if (req[owner_t'(owner + owner_t'(i))] && !(excl && i == BUS_MASTER_CH)) begin
            next_owner = owner_t'(owner + owner_t'(i));
            found = 1'b1;
         end
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: 4-master round-robin bus arbiter with grant hold and parking.
// Define BUS_ARB_TIMEOUT_EN to add the contended-hold timeout with forced handover.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
)
(
   input logic clk,
   input logic reset,
   bus_arbiter_if.slave bus
);
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT_CYCLES out of range 2..255");
   end
   mvec_t req;
   owner_t owner, nxt;
   logic found, own_req, rotate;
   assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
   assign own_req = req[owner];
   bus_arb_rr_pick u_pick (
      .owner(owner),
      .req(req),
      .excl(own_req),
      .next_owner(nxt),
      .found(found)
   );
`ifdef BUS_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic contend, expire, terr;
   assign contend = own_req && |(req & ~owner_onehot(owner));
   // hold_cnt counts completed contended cycles, so the Nth one fires on its own edge
   assign expire = contend && (hold_cnt + 8'd1 == 8'(TIMEOUT_CYCLES));
   assign rotate = found && (!own_req || expire);
   always_ff @(posedge clk)
      if (!reset) begin
         hold_cnt <= '0;
         terr <= 1'b0;
      end else begin
         hold_cnt <= (rotate || !contend) ? '0 : (&hold_cnt ? hold_cnt : hold_cnt + 8'd1);
         terr <= expire;
      end
   assign bus.timeout_err = terr;
`else
   assign rotate = found && !own_req;
   assign bus.timeout_err = 1'b0;
`endif
   always_ff @(posedge clk)
      if (!reset)
         owner <= BUS_OWNER_MASTER_0;
      else
         owner <= rotate ? nxt : owner;
   assign bus.owner = owner;
   assign {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_} = ~owner_onehot(owner);
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max consecutive contended-hold cycles before forced handover (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports m0_req_..m3_req_  input  1 each  bus request per master, active-low.
REQ-005 SHALL have ports m0_grnt_..m3_grnt_  output  1 each  bus grant per master, active-low.
REQ-006 SHALL have port owner  output  2  index of current bus owner.
REQ-007 SHALL have port timeout_err  output  1  one-cycle pulse on forced handover.

Function
REQ-008 SHALL hold owner in a register; grnt_ outputs are a combinational one-hot-low decode of owner, so exactly one grnt_ is low in every cycle.
REQ-009 SHALL keep owner unchanged while the current owner's req_ is low (grant hold, no preemption except REQ-013).
REQ-010 SHALL, when the current owner's req_ is high, select the next owner at the next edge by round-robin search starting at owner+1 (mod 4) over masters with req_ low.
REQ-011 SHALL park (keep owner unchanged) when no master requests.
REQ-012 SHALL take exactly one clock from owner releasing req_ (sampled high) to the new master's grnt_ going low; grant is never removed from one master and given to another within the same cycle as anything other than a single owner-register change.
REQ-013 SHALL count consecutive cycles in which the owner's req_ is low and at least one other req_ is low; when the count equals TIMEOUT_CYCLES, on that edge owner SHALL rotate by the REQ-010 search (excluding the current owner), and timeout_err SHALL be high for the following cycle only.
REQ-014 SHALL clear the hold counter on any owner change and in any cycle with no competing request; counter width is 8 bits, never wraps.
REQ-015 SHALL treat a master whose req_ reasserts immediately after a forced handover as an ordinary requester in later rotation.

Reset
REQ-016 SHALL, while reset is low at a rising edge, set owner=0 (m0_grnt_=0, m1..m3_grnt_=1), hold counter=0, timeout_err=0.
REQ-017 SHALL abandon any in-progress hold or pending handover when reset is asserted mid-operation; no request state is retained.

Configuration
REQ-018 SHALL compile the timeout logic of REQ-013/REQ-014 only when macro BUS_ARB_TIMEOUT_EN is defined.
REQ-019 SHALL, without BUS_ARB_TIMEOUT_EN, contain no hold counter, never preempt, and drive timeout_err constant 0 (port retained).

Structure
REQ-020 SHALL take BUS_MASTER_CH (4), the owner bus width macro and BUS_OWNER_MASTER_0..3 encodings from the shared bus header, not local literals.
REQ-021 SHALL place the round-robin search in one combinational sub-module bus_arb_rr_pick (inputs: owner, request vector, exclude-owner flag; outputs: next owner, found flag).

Verification
REQ-022 Reset: reset=0 for 2 cycles, all req_=1 -> owner=0, grnt_ = {m3..m0} 4'b1110, timeout_err=0.
REQ-023 Handover: owner=0 holding, m2_req_=0; m0_req_ rises in cycle N -> owner=2 and m2_grnt_=0 in cycle N+1, m0_grnt_=1.
REQ-024 Round-robin: owner=1 releases while m0,m2,m3 all request -> owner=2; m2 releases -> owner=3; m3 releases -> owner=0.
REQ-025 Park: owner=3 releases, no requests -> owner stays 3, m3_grnt_=0 indefinitely; m1_req_=0 later -> owner=1 one cycle after sampling.
REQ-026 Timeout (macro on, TIMEOUT_CYCLES=4): m0 holds, m1 requests continuously -> after 4 contended cycles owner=1, timeout_err high exactly 1 cycle; macro off -> m0 keeps grant, timeout_err=0.
REQ-027 Reset mid-hold: owner=2 with counter=3, reset=0 one cycle -> owner=0, counter=0, no timeout_err pulse.
